axi_ro2_lite_slave: RTL and testbench

AXI_RO2_LITE_SLAVE -- requirements
Module: axi_ro2_lite_slave

---
 rtl/axi_ro2_lite_slave_if.sv | 54 +++++
 rtl/axi_ro2_lite_slave.sv | 128 ++++++++++++
 tb/tb_axi_ro2_lite_slave.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ro2_lite_slave_if.sv
// AXI4-Lite bus bundle for axi_ro2_lite_slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R).
// The slave modport is used by the responder and the master modport by a requester.
// Clock and reset are not part of the bundle.
interface axi_ro2_lite_slave_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_ro2_lite_slave.sv
// AXI4-Lite responder with four 32-bit read/write registers at 0x0/0x4/0x8/0xC.
// Ports:
//   ACLK    - clock; all state changes on the rising edge
//   ARESET  - asynchronous active-high reset
//   s_axi   - AXI4-Lite slave bundle (AW/W/B/AR/R)
//   REG_OUT - live register contents, reg0 in [31:0] through reg3 in [127:96]
module axi_ro2_lite_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    axi_ro2_lite_slave_if.slave             s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] REG_OUT
);
    localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
    // Low for the first edge after reset so no handshake happens while leaving reset.
    logic                          r_ready_en;
    logic                          r_aw_full;
    logic [1:0]                    r_aw_idx;
    logic                          r_w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
    logic [StrbW-1:0]              r_w_strb;
    logic                          r_bvalid;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                          w_awready;
    logic                          w_wready;
    logic                          w_arready;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic                          w_commit;
    logic [1:0]                    w_wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
    logic [StrbW-1:0]              w_wr_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_val;
    logic                          w_unused;

    assign w_awready = r_ready_en && !r_aw_full && !r_bvalid;
    assign w_wready  = r_ready_en && !r_w_full && !r_bvalid;
    assign w_arready = r_ready_en && !r_rvalid;

    assign w_aw_hs = s_axi.S_AXI_AWVALID && w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID && w_wready;
    assign w_ar_hs = s_axi.S_AXI_ARVALID && w_arready;

    // Commit once both halves are either already held or arriving this edge.
    assign w_commit  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_wr_idx  = r_aw_full ? r_aw_idx : s_axi.S_AXI_AWADDR[3:2];
    assign w_wr_data = r_w_full ? r_w_data : s_axi.S_AXI_WDATA;
    assign w_wr_strb = r_w_full ? r_w_strb : s_axi.S_AXI_WSTRB;

    always_comb begin
        w_wr_val = r_regs[w_wr_idx];
        for (int b = 0; b < int'(StrbW); b++) begin
            if (w_wr_strb[b]) begin
                w_wr_val[8*b +: 8] = w_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_ready_en <= 1'b0;
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ready_en <= 1'b1;

            // Write path; a commit is only possible while BVALID is low.
            if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (w_commit) begin
                r_regs[w_wr_idx] <= w_wr_val;
                r_aw_full        <= 1'b0;
                r_w_full         <= 1'b0;
                r_bvalid         <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= s_axi.S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= s_axi.S_AXI_WDATA;
                    r_w_strb <= s_axi.S_AXI_WSTRB;
                end
            end

            // Read path samples the pre-commit register value on a same-edge collision.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_regs[s_axi.S_AXI_ARADDR[3:2]];
            end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = r_rvalid;

    assign REG_OUT = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

    // Protection bits and the byte-offset address bits carry no meaning here.
    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_ro2_lite_slave.sv
// Self-checking bench for axi_ro2_lite_slave: table-driven writes/reads with a
// read-data scoreboard, plus hand-written multi-cycle corner cases.
module tb_axi_ro2_lite_slave;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] reg_out;

    always #5 clk = ~clk;

    axi_ro2_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

    axi_ro2_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .s_axi   (bus.slave),
        .REG_OUT (reg_out)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] mdl [4];
    logic [31:0] sb [$];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every R handshake pops one expected value.
    always @(negedge clk) begin
        if (!rst && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL r_unexpected: got rdata %0h with empty scoreboard", bus.S_AXI_RDATA);
            end else begin
                check("rdata", {96'd0, bus.S_AXI_RDATA}, {96'd0, sb.pop_front()});
                check("rresp", {126'd0, bus.S_AXI_RRESP}, 128'd0);
            end
        end
    end

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl[a[3:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Write with AW and W offered together; assumes BREADY=1.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int   cnt;
        logic hs_aw, hs_w;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        cnt = 0;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && cnt < 20) begin
            hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            cnt++;
            if (hs_aw) bus.S_AXI_AWVALID = 1'b0;
            if (hs_w)  bus.S_AXI_WVALID = 1'b0;
        end
        if (bus.S_AXI_AWVALID || bus.S_AXI_WVALID) begin
            total++;
            bad++;
            $display("FAIL wr_accept_timeout: addr %0h not accepted within 20 cycles", a);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
        end
        cnt = 0;
        while (!bus.S_AXI_BVALID && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd1);
        check("bresp", {126'd0, bus.S_AXI_BRESP}, 128'd0);
        @(posedge clk); #1;
        model_write(a, d, s);
    endtask

    // Read with RREADY=1; expected value comes from the bench model.
    task automatic rd(input logic [3:0] a);
        int cnt;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        sb.push_back(mdl[a[3:2]]);
        cnt = 0;
        while (!bus.S_AXI_ARREADY && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        cnt = 0;
        while (!(bus.S_AXI_RVALID && bus.S_AXI_RREADY) && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 20) begin
            total++;
            bad++;
            $display("FAIL rd_timeout: no R handshake for addr %0h", a);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] old;
        int          cnt;

        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{4'h4, 32'h1122_3344, 4'hF, 32'h1122_3344};
        vecs[5] = '{4'h5, 32'hFFFF_FFFF, 4'h2, 32'h1122_FF44};
        vecs[6] = '{4'h4, 32'h0000_0000, 4'h0, 32'h1122_FF44};
        vecs[7] = '{4'h3, 32'hDEAD_BEEF, 4'h9, 32'hDE00_00EF};
        vecs[8] = '{4'hE, 32'hCAFE_F00D, 4'hC, 32'hCAFE_0004};
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        rst = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;

        // Reset state and ready release on the first edge after deassertion.
        #12;
        check("rst_regout", reg_out, 128'd0);
        check("rst_ready", {125'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd0);
        check("rst_valid", {126'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 128'd0);
        check("rst_rdata", {96'd0, bus.S_AXI_RDATA}, 128'd0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", {125'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
              bus.S_AXI_ARREADY}, 128'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {125'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
              bus.S_AXI_ARREADY}, 128'd7);

        // Basic write of four registers, then read all back.
        for (int i = 0; i < 4; i++) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            check("vec_regout", {96'd0, reg_out[32*vecs[i].addr[3:2] +: 32]}, {96'd0, vecs[i].exp});
        end
        check("regout_all", reg_out, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) rd(4'(i * 4));

        // Byte strobes, zero strobe, ignored low address bits.
        for (int i = 4; i < 9; i++) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            check("vec_regout", {96'd0, reg_out[32*vecs[i].addr[3:2] +: 32]}, {96'd0, vecs[i].exp});
            rd(vecs[i].addr);
        end

        // Read and write commit to reg2 on the same edge: read sees old value.
        bus.S_AXI_ARADDR = 4'h8; bus.S_AXI_ARVALID = 1'b1;
        sb.push_back(mdl[2]);
        bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h1234_5678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("collide_reg2", {96'd0, reg_out[95:64]}, {96'd0, 32'h1234_5678});
        check("collide_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd1);
        model_write(4'h8, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        check("collide_bclear", {127'd0, bus.S_AXI_BVALID}, 128'd0);

        // AW leads W by three cycles.
        bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check("late_w_awready", {127'd0, bus.S_AXI_AWREADY}, 128'd0);
            check("late_w_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd0);
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        bus.S_AXI_WDATA = 32'hA5A5_A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        check("late_w_commit_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd1);
        check("late_w_reg2", {96'd0, reg_out[95:64]}, {96'd0, 32'hA5A5_A5A5});
        model_write(4'h8, 32'hA5A5_A5A5, 4'hF);
        @(posedge clk); #1;

        // BREADY stalled for five cycles after commit.
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bstall_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd1);
            check("bstall_ready", {126'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd0);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WDATA = 32'h66; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        check("bstall_released", {127'd0, bus.S_AXI_BVALID}, 128'd0);
        check("bstall_no_early_write", {96'd0, reg_out[31:0]}, {96'd0, 32'h55});
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("bstall_second_commit", {96'd0, reg_out[31:0]}, {96'd0, 32'h66});
        check("bstall_second_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd1);
        model_write(4'h0, 32'h66, 4'hF);
        @(posedge clk); #1;

        // RDATA holds while RREADY is low and the register is overwritten.
        bus.S_AXI_RREADY = 1'b0;
        old = mdl[1];
        bus.S_AXI_ARADDR = 4'h4; bus.S_AXI_ARVALID = 1'b1;
        sb.push_back(old);
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        wr(4'h4, 32'h7777_7777, 4'hF);
        check("rhold_reg1", {96'd0, reg_out[63:32]}, {96'd0, 32'h7777_7777});
        for (int c = 0; c < 3; c++) begin
            check("rhold_rdata", {96'd0, bus.S_AXI_RDATA}, {96'd0, old});
            check("rhold_rvalid", {127'd0, bus.S_AXI_RVALID}, 128'd1);
            @(posedge clk); #1;
        end
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        check("rhold_rclear", {127'd0, bus.S_AXI_RVALID}, 128'd0);
        rd(4'h4);

        // Back-to-back reads with RREADY high: one transfer every two cycles.
        cnt = 0;
        bus.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.S_AXI_ARADDR = 4'(i * 4);
            while (!bus.S_AXI_ARREADY && cnt < 40) begin
                @(posedge clk); #1;
                cnt++;
            end
            sb.push_back(mdl[i]);
            @(posedge clk); #1;
            cnt++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        check("rd_throughput_cycles", 128'(cnt), 128'd7);
        @(posedge clk); #1;
        check("rd_throughput_drain", {127'd0, bus.S_AXI_RVALID}, 128'd0);

        // Reset between AW and W discards the held address.
        bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check("mid_aw_held", {127'd0, bus.S_AXI_AWREADY}, 128'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_regout", reg_out, 128'd0);
        check("mid_rst_state", {123'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY,
              bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        @(posedge clk); #1;
        check("mid_rst_ready", {126'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd3);
        bus.S_AXI_WDATA = 32'h99; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("w_alone_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd0);
            check("w_alone_regout", reg_out, 128'd0);
            @(posedge clk); #1;
        end
        check("w_alone_held", {126'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd2);
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check("w_then_aw_bvalid", {127'd0, bus.S_AXI_BVALID}, 128'd1);
        check("w_then_aw_regout", reg_out, {32'h99, 96'd0});
        @(posedge clk); #1;

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
